// File: rtl/modfa_ctrl.sv
// Initiator-side sequencer for one modfa adder: accepts a request, pulses mfa_en, returns the result.
// Optional range check on operands vs. the loaded modulus is compiled in with MODFA_CTRL_CHK_EN.
module modfa_ctrl #(
    parameter int WIDTH   = 256,
    parameter int TAGW    = 4,
    parameter int TMO_CYC = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mod_ld,
    input  logic [WIDTH-1:0] mod_in,
    input  logic             req_vld,
    output logic             req_rdy,
    input  logic [WIDTH-1:0] req_op1,
    input  logic [WIDTH-1:0] req_op2,
    input  logic             req_sub,
    input  logic [TAGW-1:0]  req_tag,
    output logic             rsp_vld,
    input  logic             rsp_rdy,
    output logic [WIDTH-1:0] rsp_sum,
    output logic [TAGW-1:0]  rsp_tag,
    output logic [1:0]       rsp_err,
    output logic             mfa_en,
    output logic [WIDTH-1:0] mfa_op1,
    output logic [WIDTH-1:0] mfa_op2,
    output logic [WIDTH-1:0] mfa_mod,
    output logic             mfa_cin,
    input  logic [WIDTH-1:0] mfa_sum,
    input  logic             mfa_vld,
    output logic [1:0]       dbg_state
);

    // Handshakes: a transfer happens on a rising clk edge where valid and ready are both 1;
    // the sender holds its payload stable while valid is high and ready is low.

    localparam int             CW       = $clog2(TMO_CYC);
    localparam logic [CW-1:0]  TMO_LAST = CW'(TMO_CYC - 1);
    localparam logic [1:0]     ERR_OK   = 2'b00;
    localparam logic [1:0]     ERR_RNG  = 2'b01;
    localparam logic [1:0]     ERR_TMO  = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t          state;
    logic            rdy_q;
    logic [TAGW-1:0] tag_q;
    logic [CW-1:0]   cnt;
    logic            acc;
    logic            rng_err;

    // rdy_q is a registered "sitting in IDLE" flag so req_rdy is 0 while reset is asserted.
    assign req_rdy   = rdy_q & ~mod_ld;
    assign acc       = (state == IDLE) & req_vld & req_rdy;
    assign dbg_state = state;

`ifdef MODFA_CTRL_CHK_EN
    assign rng_err = (mfa_mod == '0) || (req_op1 >= mfa_mod) || (req_op2 >= mfa_mod);
`else
    assign rng_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rdy_q   <= 1'b0;
            tag_q   <= '0;
            cnt     <= '0;
            rsp_vld <= 1'b0;
            rsp_sum <= '0;
            rsp_tag <= '0;
            rsp_err <= ERR_OK;
            mfa_en  <= 1'b0;
            mfa_op1 <= '0;
            mfa_op2 <= '0;
            mfa_mod <= '0;
            mfa_cin <= 1'b0;
        end else begin
            mfa_en <= 1'b0;
            case (state)
                IDLE: begin
                    rdy_q <= 1'b1;
                    if (mod_ld) begin
                        mfa_mod <= mod_in;
                    end else if (acc) begin
                        rdy_q <= 1'b0;
                        tag_q <= req_tag;
                        if (rng_err) begin
                            rsp_vld <= 1'b1;
                            rsp_sum <= '0;
                            rsp_tag <= req_tag;
                            rsp_err <= ERR_RNG;
                            state   <= RESP;
                        end else begin
                            mfa_op1 <= req_op1;
                            mfa_op2 <= req_op2;
                            mfa_cin <= req_sub;
                            mfa_en  <= 1'b1;
                            cnt     <= '0;
                            state   <= LAUNCH;
                        end
                    end
                end
                LAUNCH: begin
                    // modfa clears its vld on en, so anything seen here is stale
                    cnt   <= cnt + CW'(1);
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt + CW'(1);
                    if (mfa_vld) begin
                        rsp_vld <= 1'b1;
                        rsp_sum <= mfa_sum;
                        rsp_tag <= tag_q;
                        rsp_err <= ERR_OK;
                        state   <= RESP;
                    end else if (cnt == TMO_LAST) begin
                        rsp_vld <= 1'b1;
                        rsp_sum <= '0;
                        rsp_tag <= tag_q;
                        rsp_err <= ERR_TMO;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_rdy) begin
                        rsp_vld <= 1'b0;
                        rdy_q   <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_modfa_ctrl.sv
// Bench for modfa_ctrl: directed vector table, hand-written corner sequences and a randomized
// run scored against a spec-level model; a behavioural modfa responder sits on the mfa_* side.
module tb_modfa_ctrl;

    localparam int WIDTH = 8;
    localparam int TAGW  = 4;
    localparam int TMO   = 16;
    localparam int W     = TAGW + 2 + WIDTH;
`ifdef MODFA_CTRL_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             mod_ld;
    logic [WIDTH-1:0] mod_in;
    logic             req_vld;
    logic             req_rdy;
    logic [WIDTH-1:0] req_op1;
    logic [WIDTH-1:0] req_op2;
    logic             req_sub;
    logic [TAGW-1:0]  req_tag;
    logic             rsp_vld;
    logic             rsp_rdy;
    logic [WIDTH-1:0] rsp_sum;
    logic [TAGW-1:0]  rsp_tag;
    logic [1:0]       rsp_err;
    logic             mfa_en;
    logic [WIDTH-1:0] mfa_op1;
    logic [WIDTH-1:0] mfa_op2;
    logic [WIDTH-1:0] mfa_mod;
    logic             mfa_cin;
    logic [WIDTH-1:0] mfa_sum = '0;
    logic             mfa_vld = 1'b0;
    logic [1:0]       dbg_state;

    modfa_ctrl #(.WIDTH(WIDTH), .TAGW(TAGW), .TMO_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .mod_ld(mod_ld), .mod_in(mod_in),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_op1(req_op1), .req_op2(req_op2),
        .req_sub(req_sub), .req_tag(req_tag),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_sum(rsp_sum), .rsp_tag(rsp_tag),
        .rsp_err(rsp_err),
        .mfa_en(mfa_en), .mfa_op1(mfa_op1), .mfa_op2(mfa_op2), .mfa_mod(mfa_mod),
        .mfa_cin(mfa_cin), .mfa_sum(mfa_sum), .mfa_vld(mfa_vld), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    int cyc = 0;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- modfa responder ----------------
    int   resp_lat  = 1;
    bit   stray_req = 1'b0;
    int   cd        = -1;
    int   en_cnt    = 0;
    logic last_cin  = 1'b0;
    logic [WIDTH-1:0] hw_val = '0;

    function automatic logic [WIDTH-1:0] hw_modfa(int a, int b, int p, bit s);
        if (p == 0) return '0;
        if (s) return WIDTH'(((a - b) % p + p) % p);
        return WIDTH'((a + b) % p);
    endfunction

    always @(negedge clk) begin
        mfa_vld = 1'b0;
        if (!rst_n) begin
            cd = -1;
        end else begin
            if (cd > 0) begin
                cd = cd - 1;
                if (cd == 0) begin
                    mfa_vld = 1'b1;
                    mfa_sum = hw_val;
                    cd      = -1;
                end
            end
            if (mfa_en) begin
                en_cnt   = en_cnt + 1;
                last_cin = mfa_cin;
                hw_val   = hw_modfa(int'(mfa_op1), int'(mfa_op2), int'(mfa_mod), mfa_cin);
                cd       = (resp_lat > 0) ? resp_lat : -1;
            end
        end
        if (stray_req) begin
            mfa_vld   = 1'b1;
            mfa_sum   = 8'hAB;
            stray_req = 1'b0;
        end
    end

    // ---------------- scoreboard / checks ----------------
    int n_chk = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];
    int cur_mod = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] ref_sum(int a, int b, int p, bit s);
        if (s) return WIDTH'((a + p - b) % p);
        return WIDTH'((a + b) % p);
    endfunction

    function automatic logic [63:0] all_outs();
        return 64'({req_rdy, rsp_vld, rsp_sum, rsp_tag, rsp_err, mfa_en,
                    mfa_op1, mfa_op2, mfa_mod, mfa_cin});
    endfunction

    // ---------------- driver tasks ----------------
    task automatic load_mod(input logic [WIDTH-1:0] v);
        mod_ld = 1'b1;
        mod_in = v;
        #1;
        check("rdy_low_on_mod_ld", req_rdy, 0);
        @(negedge clk);
        mod_ld = 1'b0;
        #1;
        check("mod_loaded", mfa_mod, v);
        cur_mod = int'(v);
        @(negedge clk);
    endtask

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s,
                        input logic [TAGW-1:0] t, output int acc_cyc);
        bit ok;
        ok = 1'b0;
        acc_cyc = cyc;
        for (int i = 0; i < 50 && !ok; i++) begin
            req_vld = 1'b1;
            req_op1 = a;
            req_op2 = b;
            req_sub = s;
            req_tag = t;
            #1;
            if (req_rdy) begin
                ok = 1'b1;
                acc_cyc = cyc;
            end
            @(negedge clk);
        end
        req_vld = 1'b0;
        if (!ok) check("req_accept_timeout", ok, 1);
    endtask

    task automatic wait_rsp(output bit ok, output int rc);
        ok = 1'b0;
        rc = cyc;
        for (int i = 0; i < 40 && !ok; i++) begin
            #1;
            if (rsp_vld) begin
                ok = 1'b1;
                rc = cyc;
            end else begin
                @(negedge clk);
            end
        end
        if (!ok) check("rsp_wait_timeout", ok, 1);
    endtask

    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s,
                         input logic [TAGW-1:0] t, input int lat,
                         output logic [WIDTH-1:0] sum_o, output logic [TAGW-1:0] tag_o,
                         output logic [1:0] err_o, output int dly, output int en_d);
        int acc;
        int rc;
        bit ok;
        int e0;
        resp_lat = lat;
        rsp_rdy  = 1'b1;
        e0       = en_cnt;
        send(a, b, s, t, acc);
        wait_rsp(ok, rc);
        sum_o = rsp_sum;
        tag_o = rsp_tag;
        err_o = rsp_err;
        dly   = ok ? rc - acc : -1;
        @(negedge clk);
        en_d = en_cnt - e0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [WIDTH-1:0] op1;
        logic [WIDTH-1:0] op2;
        logic             sub;
        logic [TAGW-1:0]  tag;
        int               lat;
        logic [WIDTH-1:0] sum;
        logic [1:0]       err;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [WIDTH-1:0] s_o;
        logic [TAGW-1:0]  t_o;
        logic [1:0]       e_o;
        int dly, en_d, acc, rc, vcnt;
        bit ok;

        vecs[0] = '{8'd20, 8'd10, 1'b0, 4'd3,  2, 8'd7,  2'b00};
        vecs[1] = '{8'd5,  8'd9,  1'b1, 4'd5,  1, 8'd19, 2'b00};
        vecs[2] = '{8'd22, 8'd22, 1'b0, 4'd7,  3, 8'd21, 2'b00};
        vecs[3] = '{8'd0,  8'd0,  1'b1, 4'd1,  1, 8'd0,  2'b00};
        vecs[4] = '{8'd22, 8'd0,  1'b1, 4'd9,  4, 8'd22, 2'b00};
        vecs[5] = '{8'd0,  8'd22, 1'b1, 4'd12, 5, 8'd1,  2'b00};
        vecs[6] = '{8'd3,  8'd4,  1'b0, 4'd14, -1, 8'd0, 2'b10};
        vecs[7] = '{8'd11, 8'd12, 1'b0, 4'd15, 1, 8'd0,  2'b00};

        rst_n = 1'b0; mod_ld = 1'b0; mod_in = '0; req_vld = 1'b0;
        req_op1 = '0; req_op2 = '0; req_sub = 1'b0; req_tag = '0; rsp_rdy = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_outputs", all_outs(), 0);
        check("reset_state", dbg_state, 0);
        rst_n = 1'b1;
        @(negedge clk);

        load_mod(8'd23);

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].op1, vecs[i].op2, vecs[i].sub, vecs[i].tag, vecs[i].lat,
                  s_o, t_o, e_o, dly, en_d);
            check($sformatf("vec%0d_sum", i), s_o, vecs[i].sum);
            check($sformatf("vec%0d_tag", i), t_o, vecs[i].tag);
            check($sformatf("vec%0d_err", i), e_o, vecs[i].err);
            check($sformatf("vec%0d_latency", i), dly,
                  (vecs[i].err == 2'b10) ? TMO + 1 : 2 + vecs[i].lat);
            check($sformatf("vec%0d_en_pulses", i), en_d, 1);
            check($sformatf("vec%0d_cin", i), last_cin, vecs[i].sub);
        end

        // response held under back-pressure; mod_ld in RESP is dropped
        resp_lat = 1;
        rsp_rdy  = 1'b0;
        send(8'd5, 8'd9, 1'b1, 4'd6, acc);
        wait_rsp(ok, rc);
        for (int i = 0; i < 5; i++) begin
            check("hold_vld", rsp_vld, 1);
            check("hold_sum", rsp_sum, 19);
            check("hold_tag", rsp_tag, 6);
            check("hold_err", rsp_err, 0);
            check("hold_req_rdy", req_rdy, 0);
            mod_ld = 1'b1;
            mod_in = 8'd50;
            @(negedge clk);
            #1;
        end
        mod_ld  = 1'b0;
        rsp_rdy = 1'b1;
        @(negedge clk);
        #1;
        check("hold_vld_falls", rsp_vld, 0);
        check("mod_kept_after_resp_ld", mfa_mod, 23);
        @(negedge clk);

        // out-of-range operand
        do_op(8'd23, 8'd1, 1'b0, 4'd2, 1, s_o, t_o, e_o, dly, en_d);
        check("range_err", e_o, CHK ? 2'b01 : 2'b00);
        check("range_sum", s_o, CHK ? 8'd0 : 8'd1);
        check("range_tag", t_o, 2);
        check("range_en_pulses", en_d, CHK ? 0 : 1);
        check("range_latency", dly, CHK ? 1 : 3);

        // zero modulus
        load_mod(8'd0);
        do_op(8'd0, 8'd0, 1'b0, 4'd4, 1, s_o, t_o, e_o, dly, en_d);
        check("zero_mod_err", e_o, CHK ? 2'b01 : 2'b00);
        check("zero_mod_en_pulses", en_d, CHK ? 0 : 1);
        load_mod(8'd23);

        // mod_ld while waiting on modfa is dropped
        resp_lat = 6;
        rsp_rdy  = 1'b1;
        send(8'd20, 8'd10, 1'b0, 4'd8, acc);
        @(negedge clk);
        mod_ld = 1'b1;
        mod_in = 8'd97;
        repeat (2) @(negedge clk);
        mod_ld = 1'b0;
        wait_rsp(ok, rc);
        check("wait_ld_sum", rsp_sum, 7);
        check("wait_ld_mod", mfa_mod, 23);
        @(negedge clk);

        // reset mid-WAIT, then a stray mfa_vld in IDLE
        resp_lat = -1;
        send(8'd1, 8'd2, 1'b0, 4'd10, acc);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midop_reset_outputs", all_outs(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cur_mod = 0;
        stray_req = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            vcnt += int'(rsp_vld);
        end
        check("stray_vld_no_rsp", vcnt, 0);
        check("idle_ready_after_reset", req_rdy, 1);
        @(negedge clk);

        // randomized back-to-back traffic against the model
        for (int i = 0; i < 40; i++) begin
            logic [WIDTH-1:0] a, b;
            logic             s;
            logic [TAGW-1:0]  t;
            int               lat;
            logic [1:0]       e;
            logic [WIDTH-1:0] x;
            if (i == 0 || $urandom_range(0, 5) == 0) load_mod(WIDTH'($urandom_range(2, 255)));
            a   = WIDTH'($urandom_range(0, cur_mod - 1));
            b   = WIDTH'($urandom_range(0, cur_mod - 1));
            s   = 1'($urandom_range(0, 1));
            t   = TAGW'($urandom_range(0, 15));
            lat = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(1, 5));
            e   = (lat < 0) ? 2'b10 : 2'b00;
            x   = (lat < 0) ? '0 : ref_sum(int'(a), int'(b), cur_mod, s);
            exp_q.push_back({t, e, x});
            do_op(a, b, s, t, lat, s_o, t_o, e_o, dly, en_d);
            check($sformatf("rand%0d_rsp", i), {t_o, e_o, s_o}, exp_q.pop_front());
            check($sformatf("rand%0d_latency", i), dly, (lat < 0) ? TMO + 1 : 2 + lat);
            check($sformatf("rand%0d_en_pulses", i), en_d, 1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
